// File: rtl/pico_mem_pkg.sv
// Shared definitions for the pico memory responder slice.
//   state_e      : responder FSM states
//   CNT_W        : width of the wait-state down-counter
//   ERR_RDATA    : read data returned for out-of-range accesses
//   word_offset  : word distance of a byte address from the RAM base (32-bit wrap)
//   merge_bytes  : byte-lane merge of new write data into an existing word
package pico_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int CNT_W = 4;
  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  // Unsigned subtraction wraps, so addresses below the base land far out of range.
  function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pico_mem_ram.sv
// Single-port word RAM with byte-lane write enables.
//   clk   : clock, writes commit on the rising edge
//   we    : write enable
//   be    : byte-lane enables, bit n covers bits [8n+7:8n]
//   addr  : word address, shared by read and write
//   wdata : write data
//   rdata : asynchronous read of the addressed word
// Contents have no reset and are undefined until written.
module pico_mem_ram
  import pico_mem_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [WORDS];

  // Byte-masked synchronous write
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= merge_bytes(mem_r[addr], wdata, be);
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/pico_mem_responder.sv
// PicoRV32-style memory responder backed by a local RAM.
//   clk, resetn            : clock and asynchronous active-low reset
//   mem_valid/instr/addr/
//   wdata/wstrb            : request from the initiator (wstrb==0 is a read)
//   mem_ready              : one-cycle completion pulse
//   mem_rdata              : read data, zero whenever mem_ready is low
//   err_flag/err_addr      : sticky out-of-range indication and first bad address
//   err_clr                : synchronous clear of the error record
// A request is accepted in IDLE, waits WAIT_CYCLES cycles, and completes in RESP.
module pico_mem_responder
  import pico_mem_pkg::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        err_flag,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  state_e           state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      addr_r, wdata_r;
  logic [3:0]       wstrb_r;
  logic             unused_instr_r;   // captured for debug probing only
  logic             mem_ready_r, err_flag_r;
  logic [31:0]      mem_rdata_r, err_addr_r;

  logic [31:0]      look_addr_s, woff_s, ram_rdata_s;
  logic [AW-1:0]    look_index_s;
  logic             look_in_range_s, ram_we_s, resp_err_s;

  // In IDLE the live address is decoded so a zero-wait response can be
  // loaded on the accept edge; afterwards the captured address is used.
  always_comb begin
    look_addr_s = addr_r;
    if (state_r == IDLE) begin
      look_addr_s = mem_addr;
    end else begin
      look_addr_s = addr_r;
    end
  end

  assign woff_s          = word_offset(look_addr_s, BASE_ADDR);
  assign look_in_range_s = (woff_s < 32'(MEM_WORDS));
  assign look_index_s    = woff_s[AW-1:0];

  assign ram_we_s   = (state_r == RESP) && (wstrb_r != 4'b0000) && look_in_range_s;
  assign resp_err_s = (state_r == RESP) && !look_in_range_s;

  pico_mem_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .be    (wstrb_r),
    .addr  (look_index_s),
    .wdata (wdata_r),
    .rdata (ram_rdata_s)
  );

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (mem_valid) begin
          if (WAIT_CYCLES > 0) begin
            next_state_s = WAIT;
          end else begin
            next_state_s = RESP;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          next_state_s = RESP;
        end else begin
          next_state_s = WAIT;
        end
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register and wait counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if ((next_state_s == WAIT) && (state_r != WAIT)) begin
        cnt_r <= CNT_W'(WAIT_CYCLES - 1);
      end else if ((state_r == WAIT) && (cnt_r != {CNT_W{1'b0}})) begin
        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Request capture on accept; held stable for the rest of the transaction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_r         <= 32'h0000_0000;
      wdata_r        <= 32'h0000_0000;
      wstrb_r        <= 4'b0000;
      unused_instr_r <= 1'b0;
    end else if ((state_r == IDLE) && mem_valid) begin
      addr_r         <= mem_addr;
      wdata_r        <= mem_wdata;
      wstrb_r        <= mem_wstrb;
      unused_instr_r <= mem_instr;
    end
  end

  // Response outputs are loaded on the edge entering RESP so they are
  // registered and high for exactly the RESP cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready_r <= 1'b0;
      mem_rdata_r <= 32'h0000_0000;
    end else if (next_state_s == RESP) begin
      mem_ready_r <= 1'b1;
      mem_rdata_r <= look_in_range_s ? ram_rdata_s : ERR_RDATA;
    end else begin
      mem_ready_r <= 1'b0;
      mem_rdata_r <= 32'h0000_0000;
    end
  end

  // Sticky error record; a new error outranks a simultaneous clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_flag_r <= 1'b0;
      err_addr_r <= 32'h0000_0000;
    end else if (resp_err_s) begin
      err_flag_r <= 1'b1;
      if (!err_flag_r || err_clr) begin
        err_addr_r <= addr_r;
      end
    end else if (err_clr) begin
      err_flag_r <= 1'b0;
      err_addr_r <= 32'h0000_0000;
    end
  end

  assign mem_ready = mem_ready_r;
  assign mem_rdata = mem_rdata_r;
  assign err_flag  = err_flag_r;
  assign err_addr  = err_addr_r;

endmodule

// File: tb/tb_pico_mem_responder.sv
module tb_pico_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  // dut: defaults (1024 words, base 0, one wait cycle)
  logic        mem_valid, mem_instr, mem_ready, err_flag, err_clr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, err_addr;
  logic [3:0]  mem_wstrb;
  // dut0: zero wait, 64 words at base 0x8000
  logic        v0, i0, rdy0, ef0, clr0;
  logic [31:0] a0, wd0, rd0, ea0;
  logic [3:0]  ws0;

  pico_mem_responder dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err_flag(err_flag),
    .err_addr(err_addr), .err_clr(err_clr)
  );

  pico_mem_responder #(.MEM_WORDS(64), .BASE_ADDR(32'h0000_8000), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .resetn(resetn), .mem_valid(v0), .mem_instr(i0),
    .mem_addr(a0), .mem_wdata(wd0), .mem_wstrb(ws0),
    .mem_ready(rdy0), .mem_rdata(rd0), .err_flag(ef0),
    .err_addr(ea0), .err_clr(clr0)
  );

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model for dut (1024 words, base 0) ----------------
  logic [31:0] m_data  [int unsigned];
  logic [3:0]  m_known [int unsigned];
  logic        m_ef;
  logic [31:0] m_ea;

  // Returns the expected read data and a mask of bits whose value is defined.
  task automatic model_apply(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                             input bit clr, output logic [31:0] exp_rd, output logic [31:0] exp_mask);
    int unsigned w;
    w = (a - 32'h0) >> 2;
    exp_rd = 32'h0;
    exp_mask = 32'h0;
    if (w < 1024) begin
      if (!m_data.exists(w)) begin
        m_data[w] = 32'h0;
        m_known[w] = 4'h0;
      end
      if (ws == 4'h0) begin
        exp_rd = m_data[w];
        for (int b = 0; b < 4; b++)
          if (m_known[w][b]) exp_mask[8*b +: 8] = 8'hFF;
      end
      for (int b = 0; b < 4; b++) begin
        if (ws[b]) begin
          m_data[w][8*b +: 8] = wd[8*b +: 8];
          m_known[w][b] = 1'b1;
        end
      end
      if (clr) begin
        m_ef = 1'b0;
        m_ea = 32'h0;
      end
    end else begin
      exp_rd = 32'h0;
      exp_mask = 32'hFFFF_FFFF;
      if (!m_ef || clr) m_ea = a;
      m_ef = 1'b1;
    end
  endtask

  // One transaction on dut; garbage is driven on the request bus after accept.
  task automatic xact(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      input bit clr_resp, output logic [31:0] rd, output int lat);
    bit got;
    @(negedge clk);
    mem_valid = 1'b1; mem_instr = 1'($urandom_range(0, 1));
    mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    @(posedge clk);
    #1;
    mem_valid = 1'($urandom_range(0, 1));
    mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom);
    lat = 0; got = 1'b0; rd = 32'h0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (mem_ready) begin
        got = 1'b1;
        rd = mem_rdata;
        mem_valid = 1'b0;
        if (clr_resp) err_clr = 1'b1;
      end else begin
        check32("rdata_zero_when_not_ready", mem_rdata, 32'h0);
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual=no_ready required=ready addr=%h", a);
      mem_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    check32("ready_single_cycle", {31'h0, mem_ready}, 32'h0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rd;
    bit          chk_rd;
    logic        exp_ef;
    logic [31:0] exp_ea;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rd;
    bit          chk_rd;
  } op0_t;

  vec_t tbl [12];
  op0_t ops0 [8];

  initial begin
    logic [31:0] rd, er, em, a, wd;
    logic [3:0]  ws;
    int lat, k, cyc, last;
    bit clr;

    resetn = 1'b0; err_clr = 1'b0; clr0 = 1'b0;
    mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    v0 = 1'b0; i0 = 1'b1; a0 = 32'h0; wd0 = 32'h0; ws0 = 4'h0;
    m_ef = 1'b0; m_ea = 32'h0;

    tbl[0]  = '{32'h0000_0010, 32'h1122_3344, 4'hF,    32'h0,         1'b0, 1'b0, 32'h0};
    tbl[1]  = '{32'h0000_0010, 32'h0,         4'h0,    32'h1122_3344, 1'b1, 1'b0, 32'h0};
    tbl[2]  = '{32'h0000_0010, 32'hAABB_CCDD, 4'b0101, 32'h0,         1'b0, 1'b0, 32'h0};
    tbl[3]  = '{32'h0000_0013, 32'h0,         4'h0,    32'h11BB_33DD, 1'b1, 1'b0, 32'h0};
    tbl[4]  = '{32'h0000_0000, 32'h0BAD_F00D, 4'hF,    32'h0,         1'b0, 1'b0, 32'h0};
    tbl[5]  = '{32'h0000_0FFC, 32'hDEAD_BEEF, 4'hF,    32'h0,         1'b0, 1'b0, 32'h0};
    tbl[6]  = '{32'h0000_0FFC, 32'h0,         4'h0,    32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
    tbl[7]  = '{32'h0000_1000, 32'h0,         4'h0,    32'h0,         1'b1, 1'b1, 32'h0000_1000};
    tbl[8]  = '{32'h0000_2000, 32'h0,         4'h0,    32'h0,         1'b1, 1'b1, 32'h0000_1000};
    tbl[9]  = '{32'h0000_1000, 32'hFFFF_FFFF, 4'hF,    32'h0,         1'b1, 1'b1, 32'h0000_1000};
    tbl[10] = '{32'h0000_0000, 32'h0,         4'h0,    32'h0BAD_F00D, 1'b1, 1'b1, 32'h0000_1000};
    tbl[11] = '{32'h0000_0010, 32'h0,         4'h0,    32'h11BB_33DD, 1'b1, 1'b1, 32'h0000_1000};

    ops0[0] = '{32'h0000_8000, 32'hCAFE_0001, 4'hF, 32'h0,         1'b0};
    ops0[1] = '{32'h0000_8004, 32'h1234_5678, 4'hF, 32'h0,         1'b0};
    ops0[2] = '{32'h0000_80FC, 32'h0F0F_0F0F, 4'hF, 32'h0,         1'b0};
    ops0[3] = '{32'h0000_8000, 32'h0,         4'h0, 32'hCAFE_0001, 1'b1};
    ops0[4] = '{32'h0000_8004, 32'h0,         4'h0, 32'h1234_5678, 1'b1};
    ops0[5] = '{32'h0000_80FC, 32'h0,         4'h0, 32'h0F0F_0F0F, 1'b1};
    ops0[6] = '{32'h0000_8100, 32'h0,         4'h0, 32'h0,         1'b1};
    ops0[7] = '{32'h0000_7FFC, 32'h0,         4'h0, 32'h0,         1'b1};

    // reset state
    #1;
    check32("reset_ready",     {31'h0, mem_ready}, 32'h0);
    check32("reset_rdata",     mem_rdata, 32'h0);
    check32("reset_err_flag",  {31'h0, err_flag}, 32'h0);
    check32("reset_err_addr",  err_addr, 32'h0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // directed table on dut
    for (int t = 0; t < 12; t++) begin
      model_apply(tbl[t].addr, tbl[t].wdata, tbl[t].wstrb, 1'b0, er, em);
      xact(tbl[t].addr, tbl[t].wdata, tbl[t].wstrb, 1'b0, rd, lat);
      check_int($sformatf("tbl%0d_latency", t), lat, 2);
      if (tbl[t].chk_rd) check32($sformatf("tbl%0d_rdata", t), rd, tbl[t].exp_rd);
      check32($sformatf("tbl%0d_err_flag", t), {31'h0, err_flag}, {31'h0, tbl[t].exp_ef});
      check32($sformatf("tbl%0d_err_addr", t), err_addr, tbl[t].exp_ea);
    end

    // clear coinciding with a new error: the error wins and re-captures
    model_apply(32'h0000_3000, 32'h0, 4'h0, 1'b1, er, em);
    xact(32'h0000_3000, 32'h0, 4'h0, 1'b1, rd, lat);
    check32("clr_vs_err_rdata", rd, 32'h0);
    check32("clr_vs_err_flag", {31'h0, err_flag}, 32'h1);
    check32("clr_vs_err_addr", err_addr, 32'h0000_3000);

    // plain clear in idle, then a fresh capture
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    m_ef = 1'b0; m_ea = 32'h0;
    check32("clr_flag", {31'h0, err_flag}, 32'h0);
    check32("clr_addr", err_addr, 32'h0);
    model_apply(32'h0000_2000, 32'h0, 4'h0, 1'b0, er, em);
    xact(32'h0000_2000, 32'h0, 4'h0, 1'b0, rd, lat);
    check32("recapture_addr", err_addr, 32'h0000_2000);

    // randomized traffic against the model
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      wd = $urandom;
      clr = ($urandom_range(0, 5) == 0);
      model_apply(a, wd, ws, clr, er, em);
      xact(a, wd, ws, clr, rd, lat);
      check_int("rand_latency", lat, 2);
      if (em != 32'h0) check32("rand_rdata", rd & em, er & em);
      check32("rand_err_flag", {31'h0, err_flag}, {31'h0, m_ef});
      check32("rand_err_addr", err_addr, m_ea);
    end

    // dut0: zero wait, request held valid across 8 back-to-back transactions
    @(negedge clk);
    v0 = 1'b1; a0 = ops0[0].addr; wd0 = ops0[0].wdata; ws0 = ops0[0].wstrb;
    k = 0; cyc = 0; last = 0;
    for (int i = 0; i < 60 && k < 8; i++) begin
      @(negedge clk);
      cyc++;
      if (rdy0) begin
        if (k == 0) check_int("w0_first_latency", cyc, 1);
        else check_int("w0_pulse_spacing", cyc - last, 2);
        last = cyc;
        if (ops0[k].chk_rd) check32($sformatf("w0_op%0d_rdata", k), rd0, ops0[k].exp_rd);
        k++;
        if (k < 8) begin
          a0 = ops0[k].addr; wd0 = ops0[k].wdata; ws0 = ops0[k].wstrb;
        end else begin
          v0 = 1'b0;
        end
      end else begin
        check32("w0_rdata_zero", rd0, 32'h0);
      end
    end
    check_int("w0_pulse_count", k, 8);
    repeat (4) begin
      @(negedge clk);
      check32("w0_no_extra_pulse", {31'h0, rdy0}, 32'h0);
    end
    check32("w0_err_flag", {31'h0, ef0}, 32'h1);
    check32("w0_err_addr", ea0, 32'h0000_8100);

    // reset during the wait state of a write aborts it
    model_apply(32'h0000_0020, 32'h0000_0005, 4'hF, 1'b0, er, em);
    xact(32'h0000_0020, 32'h0000_0005, 4'hF, 1'b0, rd, lat);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h0000_0020; mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'hF;
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    resetn = 1'b0;
    #1;
    check32("abort_ready",    {31'h0, mem_ready}, 32'h0);
    check32("abort_rdata",    mem_rdata, 32'h0);
    check32("abort_err_flag", {31'h0, err_flag}, 32'h0);
    check32("abort_err_addr", err_addr, 32'h0);
    check32("abort_w0_err_flag", {31'h0, ef0}, 32'h0);
    repeat (3) begin
      @(negedge clk);
      check32("abort_no_ready_in_reset", {31'h0, mem_ready}, 32'h0);
    end
    resetn = 1'b1;
    m_ef = 1'b0; m_ea = 32'h0;
    repeat (3) begin
      @(negedge clk);
      check32("abort_no_ready_after", {31'h0, mem_ready}, 32'h0);
    end
    model_apply(32'h0000_0020, 32'h0, 4'h0, 1'b0, er, em);
    xact(32'h0000_0020, 32'h0, 4'h0, 1'b0, rd, lat);
    check32("abort_old_data_kept", rd, 32'h0000_0005);
    check_int("abort_read_latency", lat, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pico_mem_responder.md
PICO_MEM_RESPONDER -- requirements
Module: pico_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning RAM depth in 32-bit words, power of two.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, meaning the number of added cycles between accept and mem_ready, range 0..15.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port mem_valid  input  1  the initiator request strobe.
REQ-007 SHALL have port mem_instr  input  1  which marks the request as an instruction fetch.
REQ-008 SHALL have port mem_addr  input  32  the byte address; bits [1:0] are ignored.
REQ-009 SHALL have port mem_wdata  input  32  the write data.
REQ-010 SHALL have port mem_wstrb  input  4  the byte-lane write enables; 4'b0000 means read.
REQ-011 SHALL have port mem_ready  output  1  a one-cycle completion pulse.
REQ-012 SHALL have port mem_rdata  output  32  the read data, valid while mem_ready is high.
REQ-013 SHALL have port err_flag  output  1  a sticky out-of-range access flag.
REQ-014 SHALL have port err_addr  output  32  the address of the first out-of-range access.
REQ-015 SHALL have port err_clr  input  1  a synchronous clear of err_flag and err_addr.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 IDLE with mem_valid=1 SHALL capture addr, wdata, wstrb and instr, then go to WAIT when WAIT_CYCLES>0 or to RESP when WAIT_CYCLES=0.
REQ-018 WAIT SHALL load a 4-bit counter with WAIT_CYCLES-1 on entry, decrement it each cycle, and go to RESP on the cycle it reads 0.
REQ-019 RESP SHALL drive mem_ready=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-020 Accept-to-mem_ready latency SHALL be WAIT_CYCLES+1 cycles.
REQ-021 mem_valid SHALL be ignored outside IDLE, and request inputs SHALL NOT be resampled mid-transaction.
REQ-022 A request is in range when (addr-BASE_ADDR)>>2 < MEM_WORDS, computed with unsigned 32-bit wrap.
REQ-023 An in-range write SHALL update only the bytes whose wstrb bit is 1, committed on the RESP cycle.
REQ-024 An in-range read SHALL present the RAM word on mem_rdata during RESP.
REQ-025 A read in RESP SHALL return the newest data of the addressed word, including a write completed the previous transaction.
REQ-026 An out-of-range access SHALL still complete with mem_ready, return mem_rdata=32'h0000_0000, and drop the write.
REQ-027 On an out-of-range access, err_flag SHALL set in RESP, and err_addr SHALL capture the address only if err_flag was 0.
REQ-028 When err_clr and a new error occur in the same cycle, the error SHALL win: err_flag=1 and err_addr holds the new address.
REQ-029 mem_rdata SHALL be 32'h0 whenever mem_ready=0.
REQ-030 mem_instr SHALL have no functional effect other than being captured, and SHALL be kept for debug visibility.

Reset
REQ-031 resetn=0 SHALL asynchronously force state IDLE, counter 0, mem_ready=0, mem_rdata=0, err_flag=0 and err_addr=0.
REQ-032 Reset asserted mid-transaction SHALL abort it with no RAM write and no mem_ready pulse.
REQ-033 RAM contents SHALL NOT be reset; they are undefined until written.

Structure
REQ-034 A shared package pico_mem_pkg SHALL hold the FSM state enum (IDLE, WAIT, RESP), the read-data-on-error constant 32'h0, and the WAIT counter width.
REQ-035 One sub-module pico_mem_ram SHALL be used: a single-port RAM with byte-write enables and synchronous write; the FSM, decode and error logic stay in the top.

Verification
REQ-036 Write 32'h1122_3344 to 0x10 with wstrb=4'hF, then read 0x10: mem_rdata=32'h1122_3344, and mem_ready arrives 2 cycles after accept.
REQ-037 Write 32'hAABB_CCDD to 0x10 with wstrb=4'b0101, then read 0x10: 32'h11BB_33DD.
REQ-038 With WAIT_CYCLES=0, hold mem_valid continuously for 3 reads: mem_ready pulses every 2 cycles, and no transaction is lost or duplicated.
REQ-039 Read 0x0000_1000 (MEM_WORDS=1024): mem_ready pulses, mem_rdata=0, err_flag=1, err_addr=0x1000; a second error at 0x2000 leaves err_addr at 0x1000.
REQ-040 Assert resetn=0 during WAIT of a write to 0x20 (old value 32'h5): no mem_ready pulse occurs, and a read of 0x20 after reset returns 32'h5.
REQ-041 Pulse err_clr in the same cycle as a new error at 0x3000: err_flag=1 and err_addr=0x3000.
